// File: rtl/gray_rx_if.sv
// Gray-code receiver bus: encoder input and err_clr in, decoded position and status out.
interface gray_rx_if #(
  parameter int BITS = 8
);
  logic [BITS-1:0]    gray_in;
  logic               err_clr;
  logic [BITS-1:0]    bin_out;
  logic               step;
  logic               dir_up;
  logic signed [15:0] pos;
  logic               locked;
  logic               err;

  modport master (
    output gray_in, err_clr,
    input  bin_out, step, dir_up, pos, locked, err
  );

  modport slave (
    input  gray_in, err_clr,
    output bin_out, step, dir_up, pos, locked, err
  );
endinterface

// File: rtl/gray_rx.sv
// Gray-code position receiver: synchronise, optionally debounce, decode and track steps.
// Define GRAY_RX_DEBOUNCE_EN to require 2^LOG2STABLE stable cycles before a code is accepted.
module gray_rx #(
  parameter int BITS       = 8,
  parameter int LOG2STABLE = 4
) (
  input logic     clk,
  input logic     rst,
  gray_rx_if.slave bus
);

  typedef enum logic {INIT, TRACK} state_t;

  state_t             state, nxt_state;
  logic [BITS-1:0]    sync_p0, sync_p1;
  logic               acc_vld;
  logic [BITS-1:0]    acc_code;
  logic [BITS-1:0]    gray_q, bin_q;
  logic [BITS-1:0]    new_bin, diff;
  logic               one_bit, up;
  logic               step_q, dir_q, err_q;
  logic signed [15:0] pos_q;
  logic               do_load, do_step, do_err;

  function automatic logic [BITS-1:0] gray2bin(input logic [BITS-1:0] g);
    logic [BITS-1:0] b;
    b[BITS-1] = g[BITS-1];
    for (int i = BITS - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic signed [15:0] pos_next(input logic signed [15:0] p,
                                                  input logic              inc);
    return inc ? p + 16'sd1 : p - 16'sd1;
  endfunction

  // Stage p0/p1: two-flop synchroniser for the asynchronous encoder pins
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= bus.gray_in;
      sync_p1 <= sync_p0;
    end
  end

`ifdef GRAY_RX_DEBOUNCE_EN
  localparam int              CNT_W  = LOG2STABLE + 2;
  localparam logic [CNT_W-1:0] STABLE = CNT_W'(2 ** LOG2STABLE);

  logic [BITS-1:0]  deb_code;
  logic [CNT_W-1:0] deb_cnt;

  // Counter parks at STABLE+1 so each stable value is offered exactly once
  always_ff @(posedge clk) begin
    if (rst) begin
      deb_code <= '0;
      deb_cnt  <= '0;
    end else if (sync_p1 != deb_code) begin
      deb_code <= sync_p1;
      deb_cnt  <= CNT_W'(1);
    end else if (deb_cnt <= STABLE) begin
      deb_cnt  <= deb_cnt + CNT_W'(1);
    end
  end

  assign acc_vld  = (deb_cnt == STABLE);
  assign acc_code = deb_code;
`else
  assign acc_vld  = 1'b1;
  assign acc_code = sync_p1;

  // LOG2STABLE only shapes the debounce stage, which this build omits.
  if (LOG2STABLE < 0) begin : g_log2stable_unused
  end
`endif

  assign diff    = acc_code ^ gray_q;
  assign new_bin = gray2bin(acc_code);
  assign one_bit = (diff != '0) && ((diff & (diff - BITS'(1))) == '0);
  assign up      = (new_bin == bin_q + BITS'(1));

  always_ff @(posedge clk) begin
    if (rst) state <= INIT;
    else     state <= nxt_state;
  end

  always_comb begin
    nxt_state = state;
    if (state == INIT && acc_vld) nxt_state = TRACK;
  end

  always_comb begin
    do_load = 1'b0;
    do_step = 1'b0;
    do_err  = 1'b0;
    case (state)
      INIT: do_load = acc_vld;
      TRACK: begin
        if (acc_vld && diff != '0) begin
          do_load = 1'b1;
          do_step = one_bit;
          do_err  = !one_bit;
        end
      end
      default: ;
    endcase
  end

  // Stage p2: accepted code registered and decoded onto the outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      gray_q <= '0;
      bin_q  <= '0;
      step_q <= 1'b0;
      dir_q  <= 1'b1;
      pos_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      step_q <= do_step;
      if (do_load) begin
        gray_q <= acc_code;
        bin_q  <= new_bin;
      end
      if (do_step) begin
        dir_q <= up;
        pos_q <= pos_next(pos_q, up);
      end
      if (do_err)           err_q <= 1'b1;
      else if (bus.err_clr) err_q <= 1'b0;
    end
  end

  assign bus.bin_out = bin_q;
  assign bus.step    = step_q;
  assign bus.dir_up  = dir_q;
  assign bus.pos     = pos_q;
  assign bus.locked  = (state == TRACK);
  assign bus.err     = err_q;

endmodule

// File: tb/tb_gray_rx.sv
// Scoreboard bench for gray_rx: expected steps queued at stimulus time, popped on each step pulse.
module tb_gray_rx;
  localparam int BITS = 8;
`ifdef GRAY_RX_DEBOUNCE_EN
  localparam int LAT = 19;
`else
  localparam int LAT = 3;
`endif
  localparam int HOLD = 40;

  typedef struct {
    int bin;
    int dir;
    int pos;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  gray_rx_if #(.BITS(BITS)) bus ();

  gray_rx #(.BITS(BITS), .LOG2STABLE(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  exp_t       sb[$];
  int         nvec   = 0;
  int         nmis   = 0;
  int         nsteps = 0;
  logic       prev_step = 1'b0;
  logic [7:0] m_gray;
  int         m_bin, m_pos, m_dir, m_err;
  int         walk[10] = '{1, 2, 3, 2, 1, 0, 255, 0, 255, 0};

  task automatic check(input string tag, input int got, input int exp);
    nvec++;
    if (got != exp) begin
      nmis++;
      $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int g2b(input logic [7:0] g);
    logic [7:0] b;
    b = g;
    for (int s = 1; s < 8; s++) b = b ^ (g >> s);
    return int'(b);
  endfunction

  function automatic logic [7:0] b2g(input int b);
    logic [7:0] v;
    v = b[7:0];
    return v ^ (v >> 1);
  endfunction

  task automatic model_reset();
    sb.delete();
    m_gray = 8'h00;
    m_bin  = 0;
    m_pos  = 0;
    m_dir  = 1;
    m_err  = 0;
  endtask

  task automatic check_reset_vals(input string pfx);
    check({pfx, "_bin"},    int'(bus.bin_out), 0);
    check({pfx, "_step"},   int'(bus.step),    0);
    check({pfx, "_dir"},    int'(bus.dir_up),  1);
    check({pfx, "_pos"},    int'(bus.pos),     0);
    check({pfx, "_locked"}, int'(bus.locked),  0);
    check({pfx, "_err"},    int'(bus.err),     0);
  endtask

  // Drive one code, predict its effect, hold it and check the settled outputs.
  task automatic apply(input logic [7:0] code, input int clr_at);
    int first;
    int nb;
    int ndiff;
    first = -1;
    nb    = g2b(code);
    ndiff = $countones(code ^ m_gray);
    if (ndiff == 1) begin
      m_dir = (nb == ((m_bin + 1) % 256)) ? 1 : 0;
      m_pos = m_pos + (m_dir == 1 ? 1 : -1);
      sb.push_back('{nb, m_dir, m_pos});
    end else if (ndiff > 1) begin
      m_err = 1;
    end
    if (ndiff != 0) begin
      m_bin  = nb;
      m_gray = code;
    end
    bus.gray_in = code;
    for (int k = 1; k <= HOLD; k++) begin
      @(negedge clk);
      if (bus.step === 1'b1 && first < 0) first = k;
      bus.err_clr = (k == clr_at);
    end
    bus.err_clr = 1'b0;
    if (ndiff == 1) check("step_latency", first, LAT);
    check("sb_pending", sb.size(), 0);
    check("bin_out", int'(bus.bin_out), m_bin);
    check("pos",     int'(bus.pos),     m_pos);
    check("dir_up",  int'(bus.dir_up),  m_dir);
    check("err",     int'(bus.err),     m_err);
    check("locked",  int'(bus.locked),  1);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (bus.step === 1'b1) begin
      nsteps++;
      if (prev_step) check("double_step", 1, 0);
      if (sb.size() == 0) begin
        check("unexpected_step", 1, 0);
      end else begin
        e = sb.pop_front();
        check("step_bin", int'(bus.bin_out), e.bin);
        check("step_dir", int'(bus.dir_up),  e.dir);
        check("step_pos", int'(bus.pos),     e.pos);
      end
    end
    prev_step = bus.step;
  end

  initial begin
    int saved;
    rst         = 1'b1;
    bus.gray_in = 8'h00;
    bus.err_clr = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_vals("rst");
    rst = 1'b0;

    // Idle at gray 00: lock with no steps
    repeat (32) @(negedge clk);
    check("idle_locked", int'(bus.locked),  1);
    check("idle_bin",    int'(bus.bin_out), 0);
    check("idle_pos",    int'(bus.pos),     0);
    check("idle_err",    int'(bus.err),     0);
    check("idle_steps",  nsteps,            0);

    // Up to 3, back down, then both wrap directions through 0x80
    foreach (walk[i]) begin
      apply(b2g(walk[i]), -1);
      if (i == 2) check("up_steps", nsteps, 3);
    end

    // Two-bit jump: resync with err, no step
    saved = nsteps;
    apply(8'h03, -1);
    check("jump_no_step", nsteps, saved);
    bus.err_clr = 1'b1;
    @(negedge clk);
    bus.err_clr = 1'b0;
    check("err_clr", int'(bus.err), 0);
    m_err = 0;

    // New jump accepted in the same cycle err_clr is high: set wins
    apply(8'h0C, LAT - 1);
    apply(8'h0C, -1);

    // Reset one cycle after a valid change discards it
    saved = nsteps;
    bus.gray_in = 8'h0D;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_vals("midrst");
    rst         = 1'b0;
    bus.gray_in = 8'h00;
    model_reset();
    @(negedge clk);
    check("post_rst_step", int'(bus.step), 0);
    repeat (HOLD) @(negedge clk);
    check("rst_relock",   int'(bus.locked),  1);
    check("rst_bin",      int'(bus.bin_out), 0);
    check("rst_pos",      int'(bus.pos),     0);
    check("rst_no_steps", nsteps,            saved);

`ifdef GRAY_RX_DEBOUNCE_EN
    // Chatter shorter than the window never produces a step
    saved = nsteps;
    for (int r = 0; r < 4; r++) begin
      bus.gray_in = 8'h01;
      repeat (8) @(negedge clk);
      bus.gray_in = 8'h00;
      repeat (8) @(negedge clk);
    end
    repeat (HOLD) @(negedge clk);
    check("chatter_no_step", nsteps, saved);
    apply(8'h01, -1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
